// File: rtl/pulse_period_checker.sv
// Receive-side period/high-time checker for a clk-synchronous pulse train.
// Locks after LOCK_COUNT consecutive EXP_PERIOD periods; sticky err on loss of lock or timeout while locked.
module pulse_period_checker #(
    parameter int CNT_W      = 8,
    parameter int EXP_PERIOD = 5,
    parameter int LOCK_COUNT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pulse_in,
    input  logic             err_clr,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             locked,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE,
        ACQ,
        TRACK
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] EXP_CNT  = CNT_W'(EXP_PERIOD);
    localparam logic [3:0]       LOCK_CNT = 4'(LOCK_COUNT);

    state_t           state;
    state_t           state_nxt;
    logic             in_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] hcnt_nxt;
    logic [3:0]       match_cnt;
    logic [3:0]       match_nxt;
    logic [CNT_W-1:0] period_nxt;
    logic [CNT_W-1:0] high_nxt;
    logic             valid_nxt;
    logic             locked_nxt;
    logic             err_set;

    logic             rise;
    logic             active;
    logic             period_match;
    logic             timeout;

    assign rise         = pulse_in & ~in_d;
    assign active       = (state != IDLE);
    assign period_match = (cnt == EXP_CNT);
    assign timeout      = active && !rise && (cnt == CNT_MAX);

    // A rise restarts both counters, so at the next rise they hold the previous period and high time.
    always_comb begin
        cnt_nxt  = cnt;
        hcnt_nxt = hcnt;
        if (rise) begin
            cnt_nxt  = CNT_W'(1);
            hcnt_nxt = CNT_W'(1);
        end else if (active) begin
            if (cnt != CNT_MAX) begin
                cnt_nxt = cnt + CNT_W'(1);
            end
            if (pulse_in && (hcnt != CNT_MAX)) begin
                hcnt_nxt = hcnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        match_nxt  = match_cnt;
        period_nxt = period;
        high_nxt   = high_time;
        valid_nxt  = 1'b0;
        locked_nxt = locked;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = ACQ;
                end
            end
            ACQ: begin
                if (rise) begin
                    period_nxt = cnt;
                    high_nxt   = hcnt;
                    valid_nxt  = 1'b1;
                    if (period_match) begin
                        match_nxt = match_cnt + 4'd1;
                        if ((match_cnt + 4'd1) == LOCK_CNT) begin
                            state_nxt  = TRACK;
                            locked_nxt = 1'b1;
                        end
                    end else begin
                        match_nxt = 4'd0;
                    end
                end else if (timeout) begin
                    state_nxt  = IDLE;
                    match_nxt  = 4'd0;
                    locked_nxt = 1'b0;
                end
            end
            TRACK: begin
                if (rise) begin
                    period_nxt = cnt;
                    high_nxt   = hcnt;
                    valid_nxt  = 1'b1;
                    if (!period_match) begin
                        state_nxt  = ACQ;
                        match_nxt  = 4'd0;
                        locked_nxt = 1'b0;
                        err_set    = 1'b1;
                    end
                end else if (timeout) begin
                    state_nxt  = IDLE;
                    match_nxt  = 4'd0;
                    locked_nxt = 1'b0;
                    err_set    = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Error set takes priority over a coincident clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_d         <= 1'b0;
            cnt          <= '0;
            hcnt         <= '0;
            match_cnt    <= 4'd0;
            period       <= '0;
            high_time    <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            err          <= 1'b0;
        end else begin
            in_d         <= pulse_in;
            cnt          <= cnt_nxt;
            hcnt         <= hcnt_nxt;
            match_cnt    <= match_nxt;
            period       <= period_nxt;
            high_time    <= high_nxt;
            period_valid <= valid_nxt;
            locked       <= locked_nxt;
            if (err_set) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pulse_period_checker.sv
// Randomized and directed bench for pulse_period_checker against a timestamp-based reference model.
module tb_pulse_period_checker;

    localparam int CNT_W      = 8;
    localparam int EXP_PERIOD = 5;
    localparam int LOCK_COUNT = 3;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             pulse_in;
    logic             err_clr;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             period_valid;
    logic             locked;
    logic             err;

    int checks   = 0;
    int failures = 0;

    // Reference model: elapsed time since the last rise is taken from absolute cycle stamps.
    bit m_active;
    bit m_locked;
    bit m_err;
    bit m_prev_in;
    bit m_valid;
    int m_period;
    int m_high;
    int m_good;
    int m_cycle;
    int m_last_rise;
    int m_highs;

    always #5 clk = ~clk;

    pulse_period_checker #(
        .CNT_W     (CNT_W),
        .EXP_PERIOD(EXP_PERIOD),
        .LOCK_COUNT(LOCK_COUNT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pulse_in    (pulse_in),
        .err_clr     (err_clr),
        .period      (period),
        .high_time   (high_time),
        .period_valid(period_valid),
        .locked      (locked),
        .err         (err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, actual, expected, m_cycle);
        end
    endtask

    task automatic modelStep(input bit pin, input bit clr, input bit rst);
        bit rise;
        bit set_err;
        int since;
        if (rst) begin
            m_active  = 1'b0;
            m_locked  = 1'b0;
            m_err     = 1'b0;
            m_prev_in = 1'b0;
            m_valid   = 1'b0;
            m_period  = 0;
            m_high    = 0;
            m_good    = 0;
        end else begin
            rise    = pin && !m_prev_in;
            set_err = 1'b0;
            m_valid = 1'b0;
            since   = m_cycle - m_last_rise;
            if (rise) begin
                if (m_active) begin
                    m_period = (since > CNT_MAX) ? CNT_MAX : since;
                    m_high   = (m_highs > CNT_MAX) ? CNT_MAX : m_highs;
                    m_valid  = 1'b1;
                    if (since == EXP_PERIOD) begin
                        if (!m_locked) begin
                            m_good++;
                            if (m_good >= LOCK_COUNT) m_locked = 1'b1;
                        end
                    end else begin
                        m_good = 0;
                        if (m_locked) begin
                            m_locked = 1'b0;
                            set_err  = 1'b1;
                        end
                    end
                end
                m_active    = 1'b1;
                m_last_rise = m_cycle;
                m_highs     = 1;
            end else if (m_active) begin
                if (since >= CNT_MAX) begin
                    if (m_locked) set_err = 1'b1;
                    m_locked = 1'b0;
                    m_good   = 0;
                    m_active = 1'b0;
                end else if (pin) begin
                    m_highs++;
                end
            end
            if (set_err) m_err = 1'b1;
            else if (clr) m_err = 1'b0;
            m_prev_in = pin;
        end
        m_cycle++;
    endtask

    task automatic applyStimulus(input bit pin, input bit clr, input bit rst);
        pulse_in = pin;
        err_clr  = clr;
        reset    = rst;
        modelStep(pin, clr, rst);
        @(posedge clk);
        #1;
        checkOutput("period_valid", 32'(period_valid), 32'(m_valid));
        checkOutput("locked", 32'(locked), 32'(m_locked));
        checkOutput("err", 32'(err), 32'(m_err));
        checkOutput("period", 32'(period), 32'(m_period));
        checkOutput("high_time", 32'(high_time), 32'(m_high));
    endtask

    task automatic sendPeriod(input int p, input int h, input bit clr_at_rise);
        for (int i = 0; i < p; i++) begin
            applyStimulus(i < h, clr_at_rise && (i == 0), 1'b0);
        end
    endtask

    task automatic holdLevel(input bit level, input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(level, 1'b0, 1'b0);
        end
    endtask

    initial begin
        int p;
        int h;
        m_cycle     = 0;
        m_last_rise = 0;
        m_highs     = 0;
        reset       = 1'b1;
        pulse_in    = 1'b0;
        err_clr     = 1'b0;
        @(posedge clk);
        #1;

        // Reset, then acquire lock on a 5/2 train.
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) sendPeriod(5, 2, 1'b0);

        // Stretched period breaks lock, relock, then clear err.
        sendPeriod(6, 2, 1'b0);
        for (int i = 0; i < 4; i++) sendPeriod(5, 2, 1'b0);
        sendPeriod(5, 2, 1'b1);
        sendPeriod(5, 2, 1'b0);

        // Short period during acquisition restarts the match count without error.
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        sendPeriod(5, 2, 1'b0);
        sendPeriod(5, 2, 1'b0);
        sendPeriod(5, 2, 1'b0);
        sendPeriod(4, 2, 1'b0);
        for (int i = 0; i < 4; i++) sendPeriod(5, 2, 1'b0);

        // Timeout while locked, then reacquire.
        holdLevel(1'b0, 300);
        for (int i = 0; i < 5; i++) sendPeriod(5, 2, 1'b0);

        // Reset in the middle of tracking.
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) sendPeriod(5, 3, 1'b0);

        // Clear coinciding with a tracking mismatch, then clear alone.
        sendPeriod(7, 3, 1'b0);
        sendPeriod(5, 2, 1'b1);
        sendPeriod(5, 2, 1'b1);
        sendPeriod(5, 2, 1'b0);

        // Boundaries: minimum period, longest measurable period, one past it, constant high.
        for (int i = 0; i < 4; i++) sendPeriod(2, 1, 1'b0);
        sendPeriod(255, 10, 1'b0);
        sendPeriod(256, 10, 1'b0);
        for (int i = 0; i < 5; i++) sendPeriod(5, 2, 1'b0);
        holdLevel(1'b1, 300);
        holdLevel(1'b0, 2);
        for (int i = 0; i < 5; i++) sendPeriod(5, 4, 1'b0);

        // Randomized trains biased towards the expected period.
        for (int n = 0; n < 120; n++) begin
            p = ($urandom_range(0, 9) < 6) ? EXP_PERIOD : int'($urandom_range(2, 12));
            h = int'($urandom_range(1, p - 1));
            for (int i = 0; i < p; i++) begin
                applyStimulus(i < h, $urandom_range(0, 9) == 0, $urandom_range(0, 299) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pulse_period_checker.md
Name: pulse_period_checker

Overview:
- Receive-side companion to the team's divided-pulse generators.
- Samples a single-bit pulse train that is synchronous to clk.
- Measures the period (rising edge to rising edge) and the high time of each cycle of the train.
- Declares lock after LOCK_COUNT consecutive periods equal to EXP_PERIOD; flags loss of lock and timeouts through a sticky error bit.

Parameters:
- CNT_W, 8: width of the period and high-time counters and outputs.
- EXP_PERIOD, 5: expected period in clk cycles; range 2 to 2^CNT_W-2.
- LOCK_COUNT, 3: consecutive matching periods needed to lock; range 1 to 15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- pulse_in  in  1  pulse train, synchronous to clk, no synchronizer inside.
- err_clr  in  1  clears err (one-cycle strobe or level).
- period  out  CNT_W  last measured period, in cycles.
- high_time  out  CNT_W  high cycles within the last measured period.
- period_valid  out  1  one-cycle strobe; period and high_time updated.
- locked  out  1  lock indication.
- err  out  1  sticky error: lock lost or timeout while locked.

Behaviour:
- Reset: one clk, sampled synchronously on the rising edge, active-high.
- Reset values: period=0, high_time=0, period_valid=0, locked=0, err=0, in_d=0, cnt=0, hcnt=0, match_cnt=0, state=IDLE.
- Reset asserted mid-operation wins over every other event and clears all state at that edge.
- Edge detect:
  - in_d is pulse_in registered.
  - rise = pulse_in & ~in_d; rise is evaluated in the cycle it occurs, with no extra delay.
- Counters:
  - On any rise: cnt<=1, hcnt<=1.
  - Other cycles in ACQ or TRACK: cnt<=cnt+1, saturating at 2^CNT_W-1.
  - Other cycles in ACQ or TRACK: hcnt<=hcnt+1 when pulse_in=1, saturating.
  - Consequence: in a rise cycle, cnt equals the previous period and hcnt equals the previous high time.
- States:
  - IDLE: waits for the first rise. That rise loads the counters and moves to ACQ. It produces no measurement and no period_valid.
  - ACQ, on rise (measurement):
    - period<=cnt, high_time<=hcnt, period_valid<=1 (visible the following cycle).
    - If cnt==EXP_PERIOD: match_cnt<=match_cnt+1.
    - If cnt==EXP_PERIOD and match_cnt+1==LOCK_COUNT: go to TRACK, locked<=1 at the same edge as that period_valid.
    - If cnt!=EXP_PERIOD: match_cnt<=0, stay in ACQ.
  - TRACK, on rise:
    - Measurement reported exactly as in ACQ.
    - If cnt!=EXP_PERIOD: locked<=0, err<=1, match_cnt<=0, go to ACQ.
    - A mismatching measurement still pulses period_valid.
- Timeout:
  - In ACQ or TRACK, cnt==2^CNT_W-1 with no rise goes to IDLE, locked<=0, match_cnt<=0.
  - err<=1 only if the state was TRACK.
  - No period_valid on timeout; period and high_time hold their old values.
- period_valid is high for exactly one cycle per measurement.
- Back-to-back rises cannot occur, because a rise needs a low sample first. The minimum measurable period is 2.
- Constant-high input is not a pulse train; it ends in a timeout.
- err:
  - Set by the events above.
  - Cleared by err_clr.
  - If set and clear coincide, set wins.
- locked and err are registered outputs; there are no combinational paths from inputs to outputs.
- All arithmetic is unsigned CNT_W-bit; comparisons use full width.

Test Plan:
- Reset, then pulse_in with period 5 and high time 2, rises at cycles 2,7,12,17 -> period_valid in cycles 8,13,18, each with period=5 and high_time=2; locked=1 from cycle 18; err=0.
- While locked, stretch one period to 6 -> period_valid with period=6; locked=0 and err=1 in the same cycle as that strobe. Three further period-5 cycles -> relock. err stays 1 until an err_clr pulse clears it the next cycle.
- Period-5 train with one period of 4 inserted after two good periods while in ACQ -> match_cnt resets; lock needs three more good periods; err stays 0.
- Hold pulse_in low while locked, with CNT_W=8 -> timeout after cnt reaches 255; locked=0, err=1, state IDLE. The next rise produces no period_valid; the second rise does.
- Assert reset for one cycle in the middle of TRACK -> all outputs are 0 at the next edge. The first post-reset rise produces no measurement.
- err_clr asserted in the same cycle as a mismatch in TRACK -> err=1 (set wins). Then err_clr alone -> err=0 the next cycle.
